// File: rtl/vga_pkg.sv
// Shared types, constants and helpers for the VGA raster timing generator.
package vga_pkg;

    localparam int VGA_CORDW = 11;

    typedef struct packed {
        logic [VGA_CORDW-1:0] h_act;
        logic [VGA_CORDW-1:0] h_fp;
        logic [VGA_CORDW-1:0] h_sync;
        logic [VGA_CORDW-1:0] h_bp;
        logic [VGA_CORDW-1:0] v_act;
        logic [VGA_CORDW-1:0] v_fp;
        logic [VGA_CORDW-1:0] v_sync;
        logic [VGA_CORDW-1:0] v_bp;
    } vga_timing_t;

    typedef enum logic {
        SLOT_EMPTY   = 1'b0,
        SLOT_PENDING = 1'b1
    } slot_state_t;

    localparam vga_timing_t TIMING_600P = '{
        h_act: VGA_CORDW'(800), h_fp: VGA_CORDW'(40), h_sync: VGA_CORDW'(128), h_bp: VGA_CORDW'(88),
        v_act: VGA_CORDW'(600), v_fp: VGA_CORDW'(1),  v_sync: VGA_CORDW'(4),   v_bp: VGA_CORDW'(23)};

    localparam vga_timing_t TIMING_480P = '{
        h_act: VGA_CORDW'(640), h_fp: VGA_CORDW'(16), h_sync: VGA_CORDW'(96), h_bp: VGA_CORDW'(48),
        v_act: VGA_CORDW'(480), v_fp: VGA_CORDW'(10), v_sync: VGA_CORDW'(2),  v_bp: VGA_CORDW'(33)};

    // Two guard bits so four maximal fields cannot overflow the sum.
    function automatic logic [VGA_CORDW+1:0] total(input logic [VGA_CORDW-1:0] act, fp, sync, bp);
        return {2'b00, act} + {2'b00, fp} + {2'b00, sync} + {2'b00, bp};
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing configuration port: valid/ready offer of a new raster timing plus status pulses.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic        valid;
    logic        ready;
    vga_timing_t timing;
    logic        err;
    logic        applied;

    modport master (output valid, timing, input ready, err, applied);
    modport slave  (input valid, timing, output ready, err, applied);

endinterface

// File: rtl/vga_axis_cnt.sv
// One raster axis: position counter plus registered last/sync/active flags for that position.
module vga_axis_cnt #(
    parameter int CORDW = vga_pkg::VGA_CORDW
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic             en,
    input  logic [CORDW-1:0] len_act,
    input  logic [CORDW-1:0] len_fp,
    input  logic [CORDW-1:0] len_sync,
    input  logic [CORDW-1:0] len_bp,
    output logic [CORDW-1:0] count,
    output logic             last,
    output logic             sync_on,
    output logic             active
);
    // Lengths describe the timing in force on the next cycle, so flags stay aligned with count.
    logic [CORDW-1:0] cnt_nxt;
    logic [CORDW+1:0] nxt_w, sync_lo, sync_hi, tot_m1;

    assign sync_lo = {2'b00, len_act} + {2'b00, len_fp};
    assign sync_hi = sync_lo + {2'b00, len_sync};
    assign tot_m1  = sync_hi + {2'b00, len_bp} - 1'b1;
    assign nxt_w   = {2'b00, cnt_nxt};

    always_comb begin
        cnt_nxt = count;
        if (en) begin
            cnt_nxt = last ? '0 : count + 1'b1;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            count   <= '0;
            last    <= 1'b0;
            sync_on <= 1'b0;
            active  <= 1'b1;
        end else begin
            count   <= cnt_nxt;
            last    <= (nxt_w == tot_m1);
            sync_on <= (nxt_w >= sync_lo) && (nxt_w < sync_hi);
            active  <= (nxt_w < {2'b00, len_act});
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Runtime-reprogrammable VGA/DVI raster timing generator; new timings take effect at frame wrap.
// Optional VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter output.
//   state        | meaning
//   SLOT_EMPTY   | no timing queued, offers accepted (cfg.ready=1)
//   SLOT_PENDING | validated timing queued, applied at next frame wrap
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int          CORDW      = VGA_CORDW,
    parameter vga_timing_t DEF_TIMING = TIMING_600P,
    parameter bit          HS_ACT_HI  = 1'b0,
    parameter bit          VS_ACT_HI  = 1'b0
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    vga_timing_gen_if.slave  cfg,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line,
    output logic             frame
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);
    localparam logic [VGA_CORDW+1:0] TOT_LIMIT = (VGA_CORDW+2)'(2**VGA_CORDW);

    slot_state_t          state, state_nxt;
    vga_timing_t          cur_t, pend_t, nxt_t, offer_t;
    logic                 load, apply, reject, cfg_ok;
    logic                 err_q, applied_q;
    logic                 h_last, h_sync, h_act, v_last, v_sync, v_act;
    logic [VGA_CORDW+1:0] h_tot, v_tot;

    assign offer_t = cfg.timing;
    assign h_tot   = total(offer_t.h_act, offer_t.h_fp, offer_t.h_sync, offer_t.h_bp);
    assign v_tot   = total(offer_t.v_act, offer_t.v_fp, offer_t.v_sync, offer_t.v_bp);
    assign cfg_ok  = (offer_t.h_act != '0) && (offer_t.h_fp != '0) && (offer_t.h_sync != '0) &&
                     (offer_t.h_bp != '0) && (offer_t.v_act != '0) && (offer_t.v_fp != '0) &&
                     (offer_t.v_sync != '0) && (offer_t.v_bp != '0) &&
                     (h_tot < TOT_LIMIT) && (v_tot < TOT_LIMIT);

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        apply     = 1'b0;
        reject    = 1'b0;
        case (state)
            SLOT_EMPTY: begin
                if (cfg.valid) begin
                    if (cfg_ok) begin
                        load      = 1'b1;
                        state_nxt = SLOT_PENDING;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            SLOT_PENDING: begin
                if (frame) begin
                    apply     = 1'b1;
                    state_nxt = SLOT_EMPTY;
                end
            end
            default: state_nxt = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            cur_t     <= DEF_TIMING;
            pend_t    <= '0;
            err_q     <= 1'b0;
            applied_q <= 1'b0;
        end else begin
            err_q     <= reject;
            applied_q <= apply;
            if (load) pend_t <= offer_t;
            if (apply) cur_t <= pend_t;
        end
    end

    // Counters see the timing of the upcoming cycle so the (0,0) after a swap is already new.
    assign nxt_t = apply ? pend_t : cur_t;

    vga_axis_cnt #(.CORDW(CORDW)) u_h (
        .clk_pix  (clk_pix),
        .rst_pix_n(rst_pix_n),
        .en       (1'b1),
        .len_act  (nxt_t.h_act),
        .len_fp   (nxt_t.h_fp),
        .len_sync (nxt_t.h_sync),
        .len_bp   (nxt_t.h_bp),
        .count    (sx),
        .last     (h_last),
        .sync_on  (h_sync),
        .active   (h_act)
    );

    vga_axis_cnt #(.CORDW(CORDW)) u_v (
        .clk_pix  (clk_pix),
        .rst_pix_n(rst_pix_n),
        .en       (h_last),
        .len_act  (nxt_t.v_act),
        .len_fp   (nxt_t.v_fp),
        .len_sync (nxt_t.v_sync),
        .len_bp   (nxt_t.v_bp),
        .count    (sy),
        .last     (v_last),
        .sync_on  (v_sync),
        .active   (v_act)
    );

    assign line        = h_last;
    assign frame       = h_last & v_last;
    assign de          = h_act & v_act;
    assign hsync       = HS_ACT_HI ? h_sync : ~h_sync;
    assign vsync       = VS_ACT_HI ? v_sync : ~v_sync;
    assign cfg.ready   = (state == SLOT_EMPTY);
    assign cfg.err     = err_q;
    assign cfg.applied = applied_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            frame_cnt <= 16'd0;
        end else if (frame) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: frame-position reference model with table, random and corner sequences.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int CW = VGA_CORDW;
    // Small default raster (17 x 12 = 204 cycles per frame).
    localparam vga_timing_t TB_DEF = '{
        h_act: CW'(8), h_fp: CW'(2), h_sync: CW'(3), h_bp: CW'(4),
        v_act: CW'(6), v_fp: CW'(1), v_sync: CW'(2), v_bp: CW'(3)};

    typedef struct {
        vga_timing_t t;
        bit          exp_err;
    } vec_t;

    logic clk_pix = 1'b0;
    logic rst_pix_n = 1'b0;
    logic [CW-1:0] sx, sy;
    logic hsync, vsync, de, line, frame;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    vga_timing_gen_if cfg();

    vga_timing_gen #(
        .CORDW(CW), .DEF_TIMING(TB_DEF), .HS_ACT_HI(1'b0), .VS_ACT_HI(1'b0)
    ) dut (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .cfg(cfg),
        .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync), .de(de), .line(line), .frame(frame)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk_pix = ~clk_pix;

    int n_tests = 0;
    int n_fail = 0;

    // Reference model: position inside the frame as a linear cycle index.
    int          p;
    vga_timing_t m_t, m_pend;
    bit          m_empty, m_err, m_applied;
    int          m_fc;

    function automatic int htot(vga_timing_t t);
        return int'(t.h_act) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
    endfunction

    function automatic int vtot(vga_timing_t t);
        return int'(t.v_act) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
    endfunction

    function automatic bit legal(vga_timing_t t);
        return t.h_act != 0 && t.h_fp != 0 && t.h_sync != 0 && t.h_bp != 0 &&
               t.v_act != 0 && t.v_fp != 0 && t.v_sync != 0 && t.v_bp != 0 &&
               htot(t) < (1 << CW) && vtot(t) < (1 << CW);
    endfunction

    function automatic vga_timing_t mk(input int ha, hf, hs, hb, va, vf, vs, vb);
        vga_timing_t t;
        t = '{CW'(ha), CW'(hf), CW'(hs), CW'(hb), CW'(va), CW'(vf), CW'(vs), CW'(vb)};
        return t;
    endfunction

    function automatic vga_timing_t rand_timing();
        vga_timing_t t;
        t = mk($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6),
               $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6));
        if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 7))
                0: t.h_act = '0;
                1: t.h_fp = '0;
                2: t.h_sync = '0;
                3: t.h_bp = '0;
                4: t.v_act = '0;
                5: t.v_fp = '0;
                6: t.v_sync = '0;
                default: t.v_bp = '0;
            endcase
        end
        return t;
    endfunction

    task automatic model_reset();
        p = 0;
        m_t = TB_DEF;
        m_pend = '0;
        m_empty = 1'b1;
        m_err = 1'b0;
        m_applied = 1'b0;
        m_fc = 0;
    endtask

    task automatic check_eq(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all();
        int ht, mx, my, hs0, vs0;
        logic [CW-1:0] ex, ey;
        logic eh, ev, ede, eln, efr;
        ht  = htot(m_t);
        mx  = p % ht;
        my  = p / ht;
        hs0 = int'(m_t.h_act) + int'(m_t.h_fp);
        vs0 = int'(m_t.v_act) + int'(m_t.v_fp);
        ex  = CW'(mx);
        ey  = CW'(my);
        eh  = !(mx >= hs0 && mx < hs0 + int'(m_t.h_sync));
        ev  = !(my >= vs0 && my < vs0 + int'(m_t.v_sync));
        ede = (mx < int'(m_t.h_act)) && (my < int'(m_t.v_act));
        eln = (mx == ht - 1);
        efr = eln && (my == vtot(m_t) - 1);
        n_tests++;
        if ({sx, sy, hsync, vsync, de, line, frame, cfg.ready, cfg.err, cfg.applied} !==
            {ex, ey, eh, ev, ede, eln, efr, m_empty, m_err, m_applied}) begin
            n_fail++;
            $display("FAIL raster @%0t: got sx=%0d sy=%0d hs=%b vs=%b de=%b ln=%b fr=%b rdy=%b err=%b app=%b; expected sx=%0d sy=%0d hs=%b vs=%b de=%b ln=%b fr=%b rdy=%b err=%b app=%b",
                     $time, sx, sy, hsync, vsync, de, line, frame, cfg.ready, cfg.err, cfg.applied,
                     ex, ey, eh, ev, ede, eln, efr, m_empty, m_err, m_applied);
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        n_tests++;
        if (frame_cnt !== 16'(m_fc)) begin
            n_fail++;
            $display("FAIL frame_cnt @%0t: got %0d, expected %0d", $time, frame_cnt, m_fc);
        end
`endif
    endtask

    // One clock: capture inputs seen at the edge, advance the model, compare 1 time unit later.
    task automatic tick();
        bit xfer, wrap;
        vga_timing_t offered;
        xfer    = cfg.valid && m_empty;
        offered = cfg.timing;
        wrap    = (p == htot(m_t) * vtot(m_t) - 1);
        @(posedge clk_pix);
        #1;
        m_err = 1'b0;
        m_applied = 1'b0;
        if (wrap) begin
            p = 0;
            m_fc = (m_fc + 1) & 16'hFFFF;
            if (!m_empty) begin
                m_t = m_pend;
                m_empty = 1'b1;
                m_applied = 1'b1;
            end
        end else begin
            p++;
        end
        if (xfer) begin
            if (legal(offered)) begin
                m_pend = offered;
                m_empty = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        check_all();
    endtask

    task automatic do_reset();
        rst_pix_n = 1'b0;
        cfg.valid = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(negedge clk_pix);
        rst_pix_n = 1'b1;
    endtask

    task automatic offer(input vga_timing_t t);
        cfg.valid = 1'b1;
        cfg.timing = t;
        tick();
        cfg.valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!cfg.ready && n < 20000) begin
            tick();
            n++;
        end
        check_eq({name, "_ready_wait"}, int'(cfg.ready), 1);
    endtask

    task automatic wait_applied(input string name);
        int n = 0;
        while (!cfg.applied && n < 20000) begin
            tick();
            n++;
        end
        check_eq({name, "_applied_wait"}, int'(cfg.applied), 1);
    endtask

    task automatic measure_line(output int period);
        int n = 0;
        while (!line && n < 5000) begin
            tick();
            n++;
        end
        tick();
        period = 1;
        n = 0;
        while (!line && n < 5000) begin
            tick();
            period++;
            n++;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int n, per, first_low, low_cnt, de_cnt, ln_cnt, app_cnt;
        vga_timing_t t_a, t_c, t_d;

        vecs[0] = '{mk(1, 1, 1, 1, 1, 1, 1, 1), 1'b0};
        vecs[1] = '{mk(8, 2, 0, 4, 6, 1, 2, 3), 1'b1};
        vecs[2] = '{mk(8, 2, 3, 4, 0, 1, 2, 3), 1'b1};
        vecs[3] = '{mk(2045, 1, 1, 1, 1, 1, 1, 1), 1'b1};
        vecs[4] = '{mk(2044, 1, 1, 1, 1, 1, 1, 1), 1'b0};
        vecs[5] = '{mk(1, 1, 1, 1, 2045, 1, 1, 1), 1'b1};
        vecs[6] = '{mk(8, 2, 3, 0, 6, 1, 2, 3), 1'b1};
        vecs[7] = '{mk(10, 2, 3, 5, 8, 2, 1, 2), 1'b0};

        cfg.valid = 1'b0;
        cfg.timing = '0;
        rst_pix_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_pix);
        check_all();
        check_eq("reset_sx", int'(sx), 0);
        check_eq("reset_sy", int'(sy), 0);
        check_eq("reset_de", int'(de), 1);
        check_eq("reset_hsync", int'(hsync), 1);
        check_eq("reset_vsync", int'(vsync), 1);
        check_eq("reset_line_frame", int'({line, frame}), 0);
        check_eq("reset_ready", int'(cfg.ready), 1);
        check_eq("reset_err_applied", int'({cfg.err, cfg.applied}), 0);
        rst_pix_n = 1'b1;
        repeat (5) tick();

        // Validation table: offer each timing, check the handshake outcome and the new line length.
        foreach (vecs[i]) begin
            wait_ready($sformatf("vec%0d", i));
            offer(vecs[i].t);
            check_eq($sformatf("vec%0d_err", i), int'(cfg.err), int'(vecs[i].exp_err));
            check_eq($sformatf("vec%0d_ready", i), int'(cfg.ready), vecs[i].exp_err ? 1 : 0);
            if (!vecs[i].exp_err) begin
                wait_applied($sformatf("vec%0d", i));
                measure_line(per);
                check_eq($sformatf("vec%0d_line_period", i), per, htot(vecs[i].t));
            end
        end

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                cfg.valid = 1'b1;
                cfg.timing = rand_timing();
            end else begin
                cfg.valid = 1'b0;
            end
            tick();
        end
        cfg.valid = 1'b0;

        // Offer landing on the frame-wrap edge is held for one whole frame.
        do_reset();
        n = 0;
        while (!(cfg.ready && frame) && n < 1000) begin
            tick();
            n++;
        end
        check_eq("edge_frame_seen", int'(frame), 1);
        t_a = mk(4, 1, 2, 1, 3, 1, 1, 1);
        offer(t_a);
        check_eq("edge_no_apply", int'(cfg.applied), 0);
        check_eq("edge_ready_low", int'(cfg.ready), 0);
        n = 0;
        while (!cfg.applied && n < 1000) begin
            tick();
            n++;
        end
        check_eq("edge_apply_delay", n, 204);

        // Second offer while pending is ignored; the first one wins.
        t_c = mk(6, 1, 1, 2, 2, 1, 1, 1);
        t_d = mk(3, 1, 1, 1, 2, 1, 1, 1);
        offer(t_c);
        check_eq("pend_ready", int'(cfg.ready), 0);
        cfg.valid = 1'b1;
        cfg.timing = t_d;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("pend_ignore_ready", int'(cfg.ready), 0);
            check_eq("pend_ignore_err", int'(cfg.err), 0);
        end
        cfg.valid = 1'b0;
        wait_applied("pend");
        measure_line(per);
        check_eq("pend_line_period", per, 10);

        // 800x600 raster: hsync window and active width over the first two lines.
        offer(TIMING_600P);
        wait_applied("p600");
        first_low = -1;
        low_cnt = 0;
        de_cnt = 0;
        ln_cnt = 0;
        for (int k = 0; k < 2112; k++) begin
            if (!hsync) begin
                low_cnt++;
                if (first_low < 0) first_low = k;
            end
            if (de) de_cnt++;
            if (line) ln_cnt++;
            tick();
        end
        check_eq("p600_hs_start", first_low, 840);
        check_eq("p600_hs_low", low_cnt, 256);
        check_eq("p600_de", de_cnt, 1600);
        check_eq("p600_lines", ln_cnt, 2);

        // Reset mid-frame with a pending timing discards it and restarts the default raster.
        offer(TIMING_480P);
        check_eq("rst_pend_ready", int'(cfg.ready), 0);
        repeat (499) tick();
        check_eq("rst_at_sx", int'(sx), 500);
        check_eq("rst_at_sy", int'(sy), 2);
        do_reset();
        check_eq("rst_mid_sx", int'(sx), 0);
        check_eq("rst_mid_sy", int'(sy), 0);
        check_eq("rst_mid_ready", int'(cfg.ready), 1);
        app_cnt = 0;
        for (int k = 0; k < 3 * 204; k++) begin
            tick();
            if (cfg.applied) app_cnt++;
        end
        check_eq("rst_no_apply", app_cnt, 0);
        check_eq("rst_frames_sx", int'(sx), 0);
        check_eq("rst_frames_sy", int'(sy), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check_eq("frame_cnt_3", int'(frame_cnt), 3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
